// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and a constant-width helper.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: a - b - bin, one bit per clock, LSB
// first, through a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d_bit;
  logic             bout_bit;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign res_next = {d_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= bout_bit;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            diff  <= res_next;
            b_out <= bout_bit;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          // A start here chains straight into the next operation.
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 2, 8 and 4.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=2 instance
  logic       start2 = 0, bin2 = 0, busy2, done2, bout2;
  logic [1:0] a2 = 0, b2 = 0, diff2;
  // WIDTH=8 instance
  logic       start8 = 0, bin8 = 0, busy8, done8, bout8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  // WIDTH=4 instance
  logic       start4 = 0, bin4 = 0, busy4, done4, bout4;
  logic [3:0] a4 = 0, b4 = 0, diff4;

  serial_subtractor #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .b_out(bout2)
  );
  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8)
  );
  serial_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bout4)
  );

  // Launch one WIDTH=2 operation; lat counts negedges from the accepting edge to done.
  task automatic run2(input logic [1:0] av, input logic [1:0] bv, input logic bi,
                      output logic [2:0] res, output int lat);
    @(negedge clk);
    a2 = av; b2 = bv; bin2 = bi; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {bout2, diff2};
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                      output logic [8:0] res, output int lat, output int busy_cycles);
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res = {bout8, diff8};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy2, done2, bout2, diff2} !== 5'd0) begin
      n_fail++; $display("FAIL reset_w2: got %b, want 00000", {busy2, done2, bout2, diff2});
    end
    n_checks++;
    if ({busy8, done8, bout8, diff8} !== 11'd0) begin
      n_fail++; $display("FAIL reset_w8: got %h, want 000", {busy8, done8, bout8, diff8});
    end
    n_checks++;
    if ({busy4, done4, bout4, diff4} !== 7'd0) begin
      n_fail++; $display("FAIL reset_w4: got %h, want 00", {busy4, done4, bout4, diff4});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_width2();
    logic [1:0] va [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] vb [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
    logic       vi [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] ve [4] = '{3'b101, 3'b111, 3'b001, 3'b101};
    logic [2:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run2(va[i], vb[i], vi[i], res, lat);
      n_checks++;
      if (res !== ve[i]) begin
        n_fail++; $display("FAIL w2_vec%0d: got {b_out,diff}=%b, want %b", i, res, ve[i]);
      end
      n_checks++;
      if (lat !== 3) begin
        n_fail++; $display("FAIL w2_latency%0d: got %0d, want 3", i, lat);
      end
    end
  endtask

  task automatic test_width8();
    logic [8:0] res;
    int lat, bc;
    run8(8'hC8, 8'h37, 1'b0, res, lat, bc);
    n_checks++;
    if (res !== 9'h091) begin
      n_fail++; $display("FAIL w8_c8_37: got %h, want 091", res);
    end
    n_checks++;
    if (bc !== 8 || lat !== 9) begin
      n_fail++; $display("FAIL w8_busy_len: got busy=%0d lat=%0d, want busy=8 lat=9", bc, lat);
    end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_done_width: got done=%b busy=%b, want 0 0", done8, busy8);
    end
    run8(8'h00, 8'h00, 1'b1, res, lat, bc);
    n_checks++;
    if (res !== 9'h1FF) begin
      n_fail++; $display("FAIL w8_zero_bin: got %h, want 1ff", res);
    end
  endtask

  task automatic test_back_to_back();
    int lat, hold_err;
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h0A; bin8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if ({bout8, diff8} !== 9'h01D) begin
      n_fail++; $display("FAIL b2b_first: got %h, want 01d", {bout8, diff8});
    end
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_gap: got busy=%b done=%b, want 1 0", busy8, done8);
    end
    lat = 1;
    hold_err = 0;
    while (!done8 && lat < 40) begin
      if (diff8 !== 8'h1D) hold_err++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (hold_err !== 0) begin
      n_fail++; $display("FAIL b2b_hold: got %0d cycles with diff changed, want 0", hold_err);
    end
    n_checks++;
    if ({bout8, diff8} !== 9'h1FB || lat !== 9) begin
      n_fail++; $display("FAIL b2b_second: got %h lat=%0d, want 1fb lat=9", {bout8, diff8}, lat);
    end
  endtask

  task automatic test_start_in_run();
    int lat, extra;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    n_checks++;
    if ({bout8, diff8} !== 9'h00F || lat !== 9) begin
      n_fail++; $display("FAIL run_start_result: got %h lat=%0d, want 00f lat=9", {bout8, diff8}, lat);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy8 || done8) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL run_start_ignored: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [8:0] res;
    int lat, bc, seen;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, bout8, diff8} !== 11'd0) begin
      n_fail++; $display("FAIL mid_reset_clear: got %h, want 000", {busy8, done8, bout8, diff8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL mid_reset_no_done: got %0d active cycles, want 0", seen);
    end
    run8(8'h33, 8'h11, 1'b0, res, lat, bc);
    n_checks++;
    if (res !== 9'h022) begin
      n_fail++; $display("FAIL mid_reset_fresh: got %h, want 022", res);
    end
  endtask

  task automatic test_sweep_w4();
    logic [4:0] expv, got;
    int lat;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          a4 = 4'(ai); b4 = 4'(bi); bin4 = ci[0]; start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          lat = 1;
          while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
          end
          expv = 5'((ai - bi - ci) & 31);
          got  = {bout4, diff4};
          n_checks++;
          if (got !== expv || lat !== 5) begin
            n_fail++;
            $display("FAIL w4_sweep a=%0d b=%0d bin=%0d: got %b lat=%0d, want %b lat=5",
                     ai, bi, ci, got, lat, expv);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_width2();
    test_width8();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid_op();
    test_sweep_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the inverse-operation companion to the team's ripple-carry adder, for the EcoMender Bot datapath where area matters more than latency.
- Operands are loaded with a start/busy/done handshake.
- The result is held on registered outputs until the next completion.

Parameters:
- WIDTH, 8: operand and difference width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when the block is ready (IDLE or DONE).
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- bin  in  1  borrow-in; captured on the accepting edge.
- busy  out  1  high while the operation is in progress.
- done  out  1  one-cycle pulse; diff and b_out are valid from this cycle on.
- diff  out  WIDTH  difference.
- b_out  out  1  borrow-out.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state:
  - state = IDLE.
  - busy = 0, done = 0.
  - diff = 0, b_out = 0.
  - Internal shift registers, counter and borrow flop = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start = 1, capture a and b into shift registers, load the borrow flop with bin, clear the counter, go to RUN and set busy = 1.
  - If start = 0, stay in IDLE.
- RUN, on each edge:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift d into the result shift register from the MSB end; shift the operand registers right by 1.
  - Increment the counter.
  - On the edge that processes bit WIDTH-1:
    - copy the result shift register (including this bit) to diff and br_next to b_out;
    - set done = 1, clear busy, go to DONE.
- DONE lasts exactly one cycle, with done = 1.
  - If start = 1 in this cycle, accept a new operation exactly as from IDLE (back-to-back; busy rises on the same edge that done falls).
  - Otherwise return to IDLE with done = 0.
- Latency:
  - start accepted on edge N.
  - busy is high during cycles N+1 .. N+WIDTH.
  - done is high for exactly the one cycle following edge N+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- Arithmetic: {b_out, diff} = (a - b - bin) mod 2^(WIDTH+1). b_out = 1 exactly when a < b + bin.
- start while RUN is ignored: no capture, no effect on the operation in flight, no error flag.
- diff and b_out change only on the completion edge. They are not cleared on a new start, and they hold while the next operation runs.
- Reset asserted mid-operation aborts immediately:
  - all registers return to their reset values;
  - no done pulse is produced;
  - the partial result is discarded.
- Inputs a, b and bin may change freely after the accepting edge.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding localparams: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the default WIDTH;
  - a clog2 helper function.
- Sub-module full_subtractor: combinational inputs x, y, bin; outputs d, bout. It mirrors the team's full adder and is instantiated once.

Test Plan:
1. WIDTH=2 with the adder's vector set. Each vector -> {b_out, diff}:
   - a=01, b=11, bin=1 -> 1, 01.
   - a=11, b=11, bin=1 -> 1, 11.
   - a=10, b=01, bin=0 -> 0, 01.
   - a=00, b=11, bin=0 -> 1, 01.
   - done is high exactly 3 cycles after each start edge.
2. WIDTH=8 spot values:
   - a=0xC8, b=0x37, bin=0 -> diff=0x91, b_out=0.
   - a=0x00, b=0x00, bin=1 -> diff=0xFF, b_out=1.
   - busy is high for 8 cycles; done is high for exactly 1 cycle.
3. Back-to-back operation:
   - start held high through done; second operands a=0x05, b=0x0A, bin=0.
   - Next result diff=0xFB, b_out=1.
   - No idle cycle between operations; the first result holds on diff until the second done.
4. Start while RUN:
   - Pulse start with a=0xFF, b=0x00 at cycle N+3 of an operation with a=0x10, b=0x01.
   - Result diff=0x0F, b_out=0; no second operation starts.
5. Reset mid-operation:
   - Drop rst_n asynchronously at cycle N+4 (between edges).
   - Outputs go to 0 immediately; no done pulse follows.
   - A fresh start after release gives the correct result.
6. Exhaustive WIDTH=4 sweep: all a, b and bin combinations are checked against a reference model; no mismatches.
